// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation encodings and FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  // Signed variants need magnitude conversion up front and sign fix-up at the end.
  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference if it fits.
// Only compiled when MDU_DIV_EN is defined; without it the divider does not exist.
`ifdef MDU_DIV_EN
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_in, bit_in};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule
`endif

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. Sequence IDLE -> PREP -> RUN -> FIX.
// Optional feature macro: MDU_DIV_EN (adds DIV/DIVU; otherwise those ops are ignored).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mdu_state_t             state_reg, state_next;
  mdu_op_t                op_reg;
  logic [WIDTH-1:0]       a_reg, b_reg;
  logic [2*WIDTH-1:0]     acc_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   neg_q_reg, neg_r_reg;
  logic                   done_reg;
  logic [WIDTH-1:0]       hi_reg, lo_reg;

  logic                   op_ok;
  logic                   op_is_div;
  logic                   op_signed;
  logic [WIDTH-1:0]       abs_a, abs_b;
  logic [2*WIDTH-1:0]     mul_next;
  logic [2*WIDTH-1:0]     div_next;

`ifdef MDU_DIV_EN
  assign op_ok     = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  assign op_is_div = (op_reg == DIV) || (op_reg == DIVU);

  // Restoring divider: upper half of acc is the partial remainder, lower half shifts
  // dividend bits out of the top and quotient bits in at the bottom.
  logic [WIDTH-1:0] rem_chain [0:STEPS_PER_CYCLE];
  logic [WIDTH-1:0] quo_chain [0:STEPS_PER_CYCLE];

  assign rem_chain[0] = acc_reg[2*WIDTH-1:WIDTH];
  assign quo_chain[0] = acc_reg[WIDTH-1:0];

  for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_div
    logic q_bit;
    mdu_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_chain[gi]),
      .bit_in  (quo_chain[gi][WIDTH-1]),
      .divisor (b_reg),
      .rem_out (rem_chain[gi+1]),
      .q_bit   (q_bit)
    );
    assign quo_chain[gi+1] = {quo_chain[gi][WIDTH-2:0], q_bit};
  end

  assign div_next = {rem_chain[STEPS_PER_CYCLE], quo_chain[STEPS_PER_CYCLE]};
`else
  assign op_ok     = (op == MULT) || (op == MULTU);
  assign op_is_div = 1'b0;
  assign div_next  = acc_reg;
`endif

  assign op_signed = is_signed_op(op_reg);
  assign abs_a     = (op_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign abs_b     = (op_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  // Shift-add multiply: add multiplicand into the top half when the LSB is set, then shift right.
  always_comb begin
    logic [2*WIDTH-1:0] acc_v;
    logic [WIDTH:0]     sum_v;
    acc_v = acc_reg;
    sum_v = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      sum_v = {1'b0, acc_v[2*WIDTH-1:WIDTH]} + (acc_v[0] ? {1'b0, a_reg} : '0);
      acc_v = {sum_v, acc_v[WIDTH-1:1]};
    end
    mul_next = acc_v;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and busy decode.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: if (start && op_ok) state_next = PREP;
      PREP: begin busy = 1'b1; state_next = RUN; end
      RUN:  begin busy = 1'b1; if (cnt_reg == LAST) state_next = FIX; end
      FIX:  begin busy = 1'b1; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, magnitude prep, iteration, sign fix-up and HI/LO write.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg    <= MULT;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done_reg <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (op_ok) begin
              op_reg <= op;
              a_reg  <= a;
              b_reg  <= b;
            end else if (op == MTHI) begin
              hi_reg <= a;
            end else if (op == MTLO) begin
              lo_reg <= a;
            end
          end
        end
        PREP: begin
          a_reg     <= abs_a;
          b_reg     <= abs_b;
          cnt_reg   <= '0;
          // Divide by zero keeps the quotient all ones, so no negation for it.
          neg_q_reg <= op_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])
                       && !(op_is_div && (b_reg == '0));
          neg_r_reg <= op_signed && op_is_div && a_reg[WIDTH-1];
          acc_reg   <= op_is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          acc_reg <= op_is_div ? div_next : mul_next;
        end
        FIX: begin
          if (op_is_div) begin
            lo_reg <= neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
            hi_reg <= neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
          end else begin
            {hi_reg, lo_reg} <= neg_q_reg ? -acc_reg : acc_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model plus literal pins.
module tb_mul_div_unit;
  import mdu_pkg::*;

  parameter int STEPS = 1;
  localparam int W   = 32;
  localparam int LAT = W / STEPS + 2;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  mdu_op_t       op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .STEPS_PER_CYCLE(STEPS)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi,lo} from plain arithmetic.
  function automatic logic [2*W-1:0] ref_result(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    int sx, sy;
    logic [W-1:0] q, r;
    sx = x; sy = y;
    q = '0; r = '0;
    case (o)
      MULT:  begin p = longint'(sx) * longint'(sy); return p; end
      MULTU: return {32'd0, x} * {32'd0, y};
      DIV: begin
        if (y == 0) begin q = '1; r = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin q = 32'h8000_0000; r = 0; end
        else begin q = sx / sy; r = sx % sy; end
        return {r, q};
      end
      DIVU: begin
        if (y == 0) begin q = '1; r = x; end
        else begin q = x / y; r = x % y; end
        return {r, q};
      end
      default: return '0;
    endcase
  endfunction

  // Transaction-level model: remaining busy cycles, pending result, HI/LO.
  logic [W-1:0]   m_hi, m_lo;
  logic [2*W-1:0] m_pend;
  int             m_left;
  bit             m_done;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (op == MULT || op == MULTU || (DIV_ON && (op == DIV || op == DIVU))) begin
          m_pend = ref_result(op, a, b);
          m_left = LAT;
        end else if (op == MTHI) m_hi = a;
        else if (op == MTLO) m_lo = a;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    $display("issue op=%0d a=%h b=%h", o, x, y);
  endtask

  task automatic wait_done(input int base);
    int cyc;
    bit seen;
    cyc = base; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL done_timeout: got none expected pulse within 200 cycles");
    end else begin
      chk("latency", W'(cyc), W'(LAT));
    end
    $display("result hi=%h lo=%h after %0d cycles", hi, lo, cyc);
  endtask

  task automatic run_op(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y);
    wait_done(0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);

    // Full-width unsigned product.
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t1_hi", hi, 32'hFFFF_FFFE);
    chk("t1_lo", lo, 32'h0000_0001);
    chk("t1_model_lo", m_lo, 32'h0000_0001);

    // Signed multiply.
    run_op(MULT, 32'hFFFF_FFFD, 32'd7);
    chk("t2_hi", hi, 32'hFFFF_FFFF);
    chk("t2_lo", lo, 32'hFFFF_FFEB);
    chk("t2_model_lo", m_lo, 32'hFFFF_FFEB);
    run_op(MULT, 32'h8000_0000, 32'h8000_0000);
    chk("mult_min_hi", hi, 32'h4000_0000);
    run_op(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MULTU, 32'h0, 32'h1234_5678);
    run_op(MULT, 32'h0001_0000, 32'hFFFF_0000);

`ifdef MDU_DIV_EN
    run_op(DIV, 32'hFFFF_FFF9, 32'd2);
    chk("t2_div_lo", lo, 32'hFFFF_FFFD);
    chk("t2_div_hi", hi, 32'hFFFF_FFFF);
    run_op(DIVU, 32'h0000_1234, 32'h0);
    chk("t3_div0_lo", lo, 32'hFFFF_FFFF);
    chk("t3_div0_hi", hi, 32'h0000_1234);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("t3_ovf_lo", lo, 32'h8000_0000);
    chk("t3_ovf_hi", hi, 32'h0);
    run_op(DIV, 32'hFFFF_FF9C, 32'd7);
    run_op(DIV, 32'd100, 32'hFFFF_FFF9);
    run_op(DIV, 32'hFFFF_FFF0, 32'h0);
    run_op(DIVU, 32'hFFFF_FFFF, 32'd3);
    run_op(DIVU, 32'd5, 32'd9);
`else
    issue(DIV, 32'd10, 32'd3);
    repeat (LAT + 3) @(posedge clk);
    #1 chk("nodiv_busy", {31'd0, busy}, 32'h0);
`endif

    // Start while busy is ignored.
    issue(MULTU, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; op = MULTU; a = 32'd2; b = 32'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_done(10);
    chk("t4_hi", hi, 32'h0);
    chk("t4_lo", lo, 32'h0000_001E);

    // Reset mid-operation abandons it.
    issue(MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t4_rst_busy", {31'd0, busy}, 32'h0);
    chk("t4_rst_hi", hi, 32'h0);
    chk("t4_rst_lo", lo, 32'h0);
    repeat (LAT + 3) @(posedge clk);
    #1;

    // Back-to-back moves into HI and LO.
    start = 1'b1; op = MTHI; a = 32'hAAAA_0000;
    @(posedge clk); #1;
    chk("t5_hi", hi, 32'hAAAA_0000);
    op = MTLO; a = 32'h0000_5555;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_lo", lo, 32'h0000_5555);
    chk("t5_busy", {31'd0, busy}, 32'h0);

    // Undefined encoding is ignored.
    start = 1'b1; op = mdu_op_t'(3'd6); a = 32'hDEAD_BEEF;
    @(posedge clk); #1 start = 1'b0;
    chk("undef_hi", hi, 32'hAAAA_0000);
    repeat (3) @(posedge clk);
    #1;

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
